// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad digit entry path.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef struct packed {
    logic      legal;
    key_code_t code;
  } key_dec_t;

  localparam key_code_t KEY_BKSP = 4'hE;
  localparam key_code_t KEY_CLR  = 4'hF;

  // Keypad legend indexed by {row index, col index}.
  function automatic key_code_t key_lookup(input logic [1:0] r, input logic [1:0] c);
    key_code_t k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational one-hot row/col to key code decoder with legality flag.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [3:0] row_i,
  input  logic [3:0] col_i,
  output key_dec_t   dec_c
);

  function automatic logic [1:0] oh_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  always_comb begin
    dec_c.legal = $onehot(row_i) && $onehot(col_i);
    dec_c.code  = key_lookup(oh_idx(row_i), oh_idx(col_i));
  end

endmodule

// File: rtl/keypad_digit_shifter.sv
// Debounced keypad entry into an N-digit hex history register.
// Define KEYPAD_EDIT_EN to turn E/F into backspace/clear instead of digits.
module keypad_digit_shifter
  import keypad_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [3:0]                         row,
  input  logic [3:0]                         col,
  input  logic                               en,
  output logic [4*NUM_DIGITS-1:0]            digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]    count,
  output logic                               key_stb,
  output logic                               bad_key
);

  localparam int unsigned DW  = 4 * NUM_DIGITS;
  localparam int unsigned CW  = $clog2(NUM_DIGITS + 1);
  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DCW-1:0] CNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(NUM_DIGITS);

  state_e          state_q, state_d;
  logic [DCW-1:0]  cnt_q, cnt_d;
  logic [7:0]      rc_q, rc_d;
  key_code_t       code_q, code_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [CW-1:0]   count_q, count_d;
  logic            key_stb_q, key_stb_d;
  logic            bad_key_q, bad_key_d;
  logic            commit;
  logic [DW-1:0]   shifted;
  logic [CW-1:0]   count_inc;
  key_dec_t        dec;

  keypad_decode u_decode (
    .row_i (row),
    .col_i (col),
    .dec_c (dec)
  );

  assign shifted   = (digits_q << 4) | DW'(code_q);
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);

  // Next-state: debounce FSM, then the commit action on the captured code.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rc_d      = rc_q;
    code_d    = code_q;
    digits_d  = digits_q;
    count_d   = count_q;
    key_stb_d = 1'b0;
    bad_key_d = 1'b0;
    commit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          cnt_d = '0;
          if (dec.legal) begin
            rc_d    = {row, col};
            code_d  = dec.code;
            state_d = PRESS;
          end else begin
            bad_key_d = 1'b1;
            state_d   = RELEASE;
          end
        end
      end
      PRESS: begin
        if (!en || ({row, col} != rc_q)) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      RELEASE: begin
        if (en) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (commit) begin
      key_stb_d = 1'b1;
`ifdef KEYPAD_EDIT_EN
      if (code_q == KEY_BKSP) begin
        digits_d = digits_q >> 4;
        count_d  = (count_q == '0) ? '0 : count_q - CW'(1);
      end else if (code_q == KEY_CLR) begin
        digits_d = '0;
        count_d  = '0;
      end else begin
        digits_d = shifted;
        count_d  = count_inc;
      end
`else
      digits_d = shifted;
      count_d  = count_inc;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rc_q      <= '0;
      code_q    <= '0;
      digits_q  <= '0;
      count_q   <= '0;
      key_stb_q <= 1'b0;
      bad_key_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rc_q      <= rc_d;
      code_q    <= code_d;
      digits_q  <= digits_d;
      count_q   <= count_d;
      key_stb_q <= key_stb_d;
      bad_key_q <= bad_key_d;
    end
  end

  assign digits  = digits_q;
  assign count   = count_q;
  assign key_stb = key_stb_q;
  assign bad_key = bad_key_q;

endmodule

// File: tb/tb_keypad_digit_shifter.sv
// Directed self-checking bench for keypad_digit_shifter (NUM_DIGITS=2, DEBOUNCE_CYCLES=4).
module tb_keypad_digit_shifter;

  localparam int unsigned ND  = 2;
  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row = 4'h0;
  logic [3:0] col = 4'h0;
  logic       en = 1'b0;
  logic [7:0] digits;
  logic [1:0] count;
  logic       key_stb;
  logic       bad_key;

  int checks = 0;
  int passed = 0;
  int stb_cnt = 0;
  int bad_cnt = 0;

  keypad_digit_shifter #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .row     (row),
    .col     (col),
    .en      (en),
    .digits  (digits),
    .count   (count),
    .key_stb (key_stb),
    .bad_key (bad_key)
  );

  always #5 clk = ~clk;

  // Pulse tallies, taken at the edge that ends each pulse cycle.
  always @(posedge clk) begin
    if (key_stb === 1'b1) stb_cnt <= stb_cnt + 1;
    if (bad_key === 1'b1) bad_cnt <= bad_cnt + 1;
  end

  task automatic drive(input logic e, input logic [3:0] r, input logic [3:0] c, input int n);
    en = e; row = r; col = c;
    repeat (n) @(negedge clk);
  endtask

  // Full press (DEB+1 sampled edges) followed by a debounced release.
  task automatic key(input logic [3:0] r, input logic [3:0] c);
    drive(1'b1, r, c, DEB + 1);
    drive(1'b0, 4'h0, 4'h0, DEB);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (digits !== 8'h00) $display("FAIL reset_digits got %h want 00", digits); else passed++;
    checks++;
    if ({count, key_stb, bad_key} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {count, key_stb, bad_key}); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    int s0;
    s0 = stb_cnt;
    drive(1'b1, 4'b0001, 4'b0010, DEB);
    checks++;
    if ({digits, key_stb} !== {8'h00, 1'b0})
      $display("FAIL single_early got %h/%b want 00/0", digits, key_stb); else passed++;
    drive(1'b1, 4'b0001, 4'b0010, 1);
    checks++;
    if ({digits, count, key_stb} !== {8'h02, 2'd1, 1'b1})
      $display("FAIL single_commit got %h/%0d/%b want 02/1/1", digits, count, key_stb); else passed++;
    drive(1'b0, 4'h0, 4'h0, DEB);
    checks++;
    if (stb_cnt - s0 !== 1) $display("FAIL single_stb_count got %0d want 1", stb_cnt - s0); else passed++;
  endtask

  task automatic test_saturate;
    key(4'b0001, 4'b0001);
    checks++;
    if ({digits, count} !== {8'h21, 2'd2})
      $display("FAIL sat_after_1 got %h/%0d want 21/2", digits, count); else passed++;
    key(4'b0001, 4'b0010);
    key(4'b0001, 4'b0100);
    checks++;
    if ({digits, count} !== {8'h23, 2'd2})
      $display("FAIL sat_after_3 got %h/%0d want 23/2", digits, count); else passed++;
  endtask

  task automatic test_no_commit;
    int s0;
    s0 = stb_cnt;
    drive(1'b1, 4'b0010, 4'b0010, DEB);
    drive(1'b0, 4'h0, 4'h0, DEB);
    checks++;
    if (digits !== 8'h23) $display("FAIL short_press got %h want 23", digits); else passed++;
    drive(1'b1, 4'b0010, 4'b0010, 2);
    drive(1'b1, 4'b0010, 4'b0100, 3);
    drive(1'b0, 4'h0, 4'h0, DEB);
    checks++;
    if ({digits, count} !== {8'h23, 2'd2})
      $display("FAIL col_change got %h/%0d want 23/2", digits, count); else passed++;
    checks++;
    if (stb_cnt - s0 !== 0) $display("FAIL no_commit_stb got %0d want 0", stb_cnt - s0); else passed++;
  endtask

  task automatic test_bad_key;
    int s0, b0;
    s0 = stb_cnt; b0 = bad_cnt;
    drive(1'b1, 4'b0011, 4'b0001, 1);
    checks++;
    if (bad_key !== 1'b1) $display("FAIL bad_pulse got %b want 1", bad_key); else passed++;
    drive(1'b1, 4'b0011, 4'b0001, 1);
    checks++;
    if (bad_key !== 1'b0) $display("FAIL bad_pulse_width got %b want 0", bad_key); else passed++;
    drive(1'b1, 4'b0011, 4'b0001, 18);
    drive(1'b0, 4'h0, 4'h0, DEB);
    checks++;
    if (bad_cnt - b0 !== 1) $display("FAIL bad_count got %0d want 1", bad_cnt - b0); else passed++;
    checks++;
    if ({digits, stb_cnt - s0} !== {8'h23, 32'd0})
      $display("FAIL bad_no_commit got %h/%0d want 23/0", digits, stb_cnt - s0); else passed++;
  endtask

  task automatic test_hold_glitch;
    int s0;
    s0 = stb_cnt;
    drive(1'b1, 4'b0100, 4'b0001, 50);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'h0, 4'h0, 2);
      drive(1'b1, 4'b0100, 4'b0001, 2);
    end
    drive(1'b0, 4'h0, 4'h0, DEB);
    checks++;
    if (stb_cnt - s0 !== 1) $display("FAIL hold_commits got %0d want 1", stb_cnt - s0); else passed++;
    checks++;
    if ({digits, count} !== {8'h37, 2'd2})
      $display("FAIL hold_digits got %h/%0d want 37/2", digits, count); else passed++;
    key(4'b0100, 4'b0010);
    checks++;
    if (digits !== 8'h78) $display("FAIL after_release got %h want 78", digits); else passed++;
  endtask

  task automatic test_edit;
    int s0;
    key(4'b0010, 4'b0001);
    key(4'b0100, 4'b0100);
    checks++;
    if (digits !== 8'h49) $display("FAIL edit_setup got %h want 49", digits); else passed++;
    key(4'b1000, 4'b0001);
`ifdef KEYPAD_EDIT_EN
    checks++;
    if ({digits, count} !== {8'h04, 2'd1})
      $display("FAIL bksp got %h/%0d want 04/1", digits, count); else passed++;
    key(4'b1000, 4'b0100);
    checks++;
    if ({digits, count} !== {8'h00, 2'd0})
      $display("FAIL clr got %h/%0d want 00/0", digits, count); else passed++;
    s0 = stb_cnt;
    key(4'b1000, 4'b0001);
    checks++;
    if ({digits, count, stb_cnt - s0} !== {8'h00, 2'd0, 32'd1})
      $display("FAIL bksp_empty got %h/%0d/%0d want 00/0/1", digits, count, stb_cnt - s0); else passed++;
`else
    checks++;
    if ({digits, count} !== {8'h9E, 2'd2})
      $display("FAIL e_digit got %h/%0d want 9e/2", digits, count); else passed++;
    s0 = stb_cnt;
    key(4'b1000, 4'b0100);
    checks++;
    if ({digits, stb_cnt - s0} !== {8'hEF, 32'd1})
      $display("FAIL f_digit got %h/%0d want ef/1", digits, stb_cnt - s0); else passed++;
`endif
  endtask

  task automatic test_reset_mid;
    key(4'b0001, 4'b0100);
    drive(1'b1, 4'b0001, 4'b0001, 3);
    #2 rst_n = 1'b0;
    en = 1'b0; row = 4'h0; col = 4'h0;
    #1;
    checks++;
    if ({digits, count, key_stb, bad_key} !== 12'h000)
      $display("FAIL async_reset got %h/%0d/%b/%b want 00/0/0/0", digits, count, key_stb, bad_key); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key(4'b0001, 4'b0010);
    checks++;
    if ({digits, count} !== {8'h02, 2'd1})
      $display("FAIL post_reset got %h/%0d want 02/1", digits, count); else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_saturate;
    test_no_commit;
    test_bad_key;
    test_hold_glitch;
    test_edit;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
